zigbee_pad_arbiter: RTL and testbench
=====================================

Name: zigbee_pad_arbiter

Overview:
- Shares the platform's single pad-mux bus (22-bit pad input, 18-bit pad output, 2-bit select) between up to N_REQ internal requesters: test/debug channels, radio-front-end observation, BIST.
- Sits between the requesters and the pad ring.
- Drives the pad select and the granted requester's output data.
- Uses round-robin arbitration, a bounded ownership time, and guard cycles on every select change so the pads settle.

Parameters:
- N_REQ, 4: number of requesters (2..4).
- SEL_W, 2: select width, $clog2(N_REQ) (minimum 1).
- IN_W, 22: pad input bus width.
- OUT_W, 18: pad output bus width.
- GUARD, 2: settle cycles after a select change before grant (0..15).
- MAX_HOLD, 64: ownership cycles before preemption when others wait (0 = never preempt).

Ports:
- clk_i, in, 1: clock.
- rst_i, in, 1: reset. Asynchronous, active-high.
- req_i, in, N_REQ: per-requester bus request, level.
- data_i, in, N_REQ*OUT_W: per-requester output data; requester k owns bits [k*OUT_W +: OUT_W].
- pad_in_i, in, IN_W: pad input bus.
- gnt_o, out, N_REQ: one-hot grant, registered.
- sel_o, out, SEL_W: pad mux select, registered.
- pad_out_o, out, OUT_W: bus driven to the pads.
- in_o, out, IN_W: pad_in_i broadcast to all requesters.
- in_vld_o, out, N_REQ: equals gnt_o.
- busy_o, out, 1: high in GUARD or OWN.

Behaviour:
- Reset (async, any time, including mid-GUARD or mid-OWN):
  - state=IDLE, gnt_o=0, sel_o=0, busy_o=0.
  - RR pointer=0, hold counter=0, guard counter=0.
  - pad_out_o=0 immediately.
- States: IDLE, GUARD, OWN.
- Arbitration (IDLE only, one cycle):
  - Winner is the first asserted req_i at or after the RR pointer, wrapping modulo N_REQ.
  - No request: stay in IDLE with all outputs held.
- IDLE -> GUARD when winner != sel_o and GUARD>0:
  - sel_o<=winner; guard counter<=GUARD-1.
  - gnt_o stays 0.
- IDLE -> OWN directly when winner==sel_o (no pad switch) or GUARD==0:
  - gnt_o<=onehot(winner); sel_o<=winner.
- GUARD:
  - Counter decrements each cycle. At 0: go to OWN, gnt_o<=onehot(sel_o), hold counter<=0.
  - If req_i[sel_o] drops during GUARD: go to IDLE, no grant issued. sel_o retains its value and the RR pointer is unchanged.
- Latency from a req_i rising edge while idle:
  - Switched select: sel_o changes 1 cycle later; gnt_o rises 1+GUARD cycles later.
  - Same select: gnt_o rises 1 cycle later.
- OWN:
  - Hold counter increments, saturating at MAX_HOLD.
  - Owner drops req_i: next edge go to IDLE, gnt_o<=0, pointer<=owner+1 (mod N_REQ).
  - Preemption: hold counter==MAX_HOLD, MAX_HOLD!=0, and any other req_i asserted. Next edge gnt_o<=0, pointer<=owner+1, go to IDLE. The owner's req_i need not drop.
  - Counter at MAX_HOLD with no other request: keep ownership, no preemption.
  - Owner release and a new request in the same cycle: release takes effect; the new request is arbitrated in the following IDLE cycle.
- pad_out_o (combinational): data_i slice of sel_o when state==OWN, else 0. Never drives a non-granted requester's data.
- in_o=pad_in_i (combinational). in_vld_o=gnt_o.
- Invariants:
  - gnt_o is one-hot or zero.
  - gnt_o!=0 implies gnt_o[sel_o]=1.
  - sel_o never changes while gnt_o!=0.

Test Plan (GUARD=2, MAX_HOLD=64, N_REQ=4):
1. Reset release, req_i=0010 at cycle 0 -> sel_o=1 at cycle 1; gnt_o=0010 at cycle 3. pad_out_o=0 through cycle 2, then data_i[35:18]=0x2A5A5.
2. req_i=1111 held for 400 cycles -> grants in order 0,1,2,3,0. Each owns exactly 65 cycles, with an IDLE cycle plus 2 GUARD cycles between owners; gnt_o is never multi-hot.
3. req0 owns, drops req, re-requests 1 cycle later with no other requests -> no guard; gnt_o=0001 returns 2 cycles after the drop; sel_o stays 0.
4. req3 asserted, then deasserted at the first GUARD cycle -> no grant; state returns to IDLE; sel_o=3; pad_out_o stays 0.
5. req2 alone held for 200 cycles -> gnt_o=0100 continuously with no preemption. req0 asserted at cycle 150 -> req2 released the next cycle; req0 is granted after the IDLE cycle plus 2 GUARD cycles.
6. rst_i pulsed mid-OWN (owner 1, data 0x3FFFF) -> gnt_o, sel_o and pad_out_o are 0 before the next clock edge. After release, the pointer is 0: req_i=1010 grants 1 first.

Source files
------------

// File: rtl/zigbee_pad_arbiter.sv
// Pad-mux arbiter: shares one pad bus among N_REQ requesters with round-robin
// selection, bounded ownership and settle (guard) cycles on every select change.
module zigbee_pad_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SEL_W    = (N_REQ > 2) ? $clog2(N_REQ) : 1,
  parameter int IN_W     = 22,
  parameter int OUT_W    = 18,
  parameter int GUARD    = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*OUT_W-1:0] data_i,
  input  logic [IN_W-1:0]        pad_in_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [SEL_W-1:0]       sel_o,
  output logic [OUT_W-1:0]       pad_out_o,
  output logic [IN_W-1:0]        in_o,
  output logic [N_REQ-1:0]       in_vld_o,
  output logic                   busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;

  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [3:0]        GUARD_INIT = (GUARD > 0) ? 4'(GUARD - 1) : 4'd0;
  localparam logic [SEL_W-1:0]  LAST_SEL   = SEL_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  ONE_HOT0   = N_REQ'(1);

  logic [1:0]        state_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [SEL_W-1:0]  ptr_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [3:0]        guard_reg;

  logic [SEL_W-1:0]  win_next;
  logic              win_found;
  logic [SEL_W-1:0]  ptr_next;
  logic              preempt;
  logic [OUT_W-1:0]  slice [N_REQ];

  // Round-robin search: first asserted request at or after the pointer, wrapping.
  always_comb begin
    win_next  = '0;
    win_found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!win_found && req_i[k] && (((k - off + N_REQ) % N_REQ) == int'(ptr_reg))) begin
          win_next  = SEL_W'(k);
          win_found = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the owner on release; another requester waiting at
  // saturation forces the owner off the bus.
  always_comb begin
    ptr_next = (sel_reg == LAST_SEL) ? '0 : sel_reg + 1'b1;
    preempt  = (MAX_HOLD != 0) && (hold_reg == HOLD_MAX) && (|(req_i & ~gnt_reg));
  end

  // Arbitration state machine; async reset returns everything to an idle, ungranted bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      gnt_reg   <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      hold_reg  <= '0;
      guard_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (win_found) begin
            sel_reg <= win_next;
            if ((win_next != sel_reg) && (GUARD > 0)) begin
              state_reg <= ST_GUARD;
              guard_reg <= GUARD_INIT;
            end else begin
              state_reg <= ST_OWN;
              gnt_reg   <= ONE_HOT0 << win_next;
              hold_reg  <= '0;
            end
          end
        end
        ST_GUARD: begin
          if (!req_i[sel_reg]) begin
            // Requester gave up while pads settled: no grant, pointer untouched.
            state_reg <= ST_IDLE;
          end else if (guard_reg == 4'd0) begin
            state_reg <= ST_OWN;
            gnt_reg   <= ONE_HOT0 << sel_reg;
            hold_reg  <= '0;
          end else begin
            guard_reg <= guard_reg - 1'b1;
          end
        end
        ST_OWN: begin
          if (!req_i[sel_reg] || preempt) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            ptr_reg   <= ptr_next;
          end else if (hold_reg != HOLD_MAX) begin
            hold_reg <= hold_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice[gi] = data_i[gi*OUT_W +: OUT_W];
  end

  // Only the owner's data reaches the pads; zero otherwise (including in reset).
  assign pad_out_o = (state_reg == ST_OWN) ? slice[sel_reg] : '0;
  assign in_o      = pad_in_i;
  assign gnt_o     = gnt_reg;
  assign in_vld_o  = gnt_reg;
  assign sel_o     = sel_reg;
  assign busy_o    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_zigbee_pad_arbiter.sv
// Directed bench for zigbee_pad_arbiter: vector table plus multi-cycle sequences.
module tb_zigbee_pad_arbiter;

  localparam int N_REQ = 4;
  localparam int OUT_W = 18;
  localparam int IN_W  = 22;
  localparam logic [17:0] D0 = 18'h01234;
  localparam logic [17:0] D1 = 18'h2A5A5;
  localparam logic [17:0] D2 = 18'h0BEEF;
  localparam logic [17:0] D3 = 18'h15555;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic [N_REQ-1:0]       req_i = '0;
  logic [N_REQ*OUT_W-1:0] data_i;
  logic [IN_W-1:0]        pad_in_i = 22'h2BCDE1;
  logic [N_REQ-1:0]       gnt_o;
  logic [1:0]             sel_o;
  logic [OUT_W-1:0]       pad_out_o;
  logic [IN_W-1:0]        in_o;
  logic [N_REQ-1:0]       in_vld_o;
  logic                   busy_o;

  logic [17:0] d [4];
  assign data_i = {d[3], d[2], d[1], d[0]};

  zigbee_pad_arbiter #(
    .N_REQ(4), .SEL_W(2), .IN_W(22), .OUT_W(18), .GUARD(2), .MAX_HOLD(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .pad_in_i(pad_in_i), .gnt_o(gnt_o), .sel_o(sel_o), .pad_out_o(pad_out_o),
    .in_o(in_o), .in_vld_o(in_vld_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [17:0] pad;
    logic        busy;
  } vec_t;

  vec_t vecs [19];
  int n_checks = 0;
  int n_fail   = 0;

  int run_idx, cur_len, gap, viol, bad;
  int owners [8];
  int lens [8];
  logic [3:0] prev_gnt;
  logic [1:0] prev_sel;
  logic [3:0] g;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = '0;
    step();
    step();
    chk("rst.gnt",  32'(gnt_o), 32'h0);
    chk("rst.sel",  32'(sel_o), 32'h0);
    chk("rst.pad",  32'(pad_out_o), 32'h0);
    chk("rst.busy", 32'(busy_o), 32'h0);
    chk("rst.vld",  32'(in_vld_o), 32'h0);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    d[0] = D0; d[1] = D1; d[2] = D2; d[3] = D3;

    vecs[0]  = '{4'b0010, 4'b0000, 2'd1, 18'h0, 1'b1};
    vecs[1]  = '{4'b0010, 4'b0000, 2'd1, 18'h0, 1'b1};
    vecs[2]  = '{4'b0010, 4'b0010, 2'd1, D1,    1'b1};
    vecs[3]  = '{4'b0010, 4'b0010, 2'd1, D1,    1'b1};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd1, 18'h0, 1'b0};
    vecs[5]  = '{4'b0010, 4'b0010, 2'd1, D1,    1'b1};
    vecs[6]  = '{4'b0001, 4'b0000, 2'd1, 18'h0, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0000, 2'd0, 18'h0, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0000, 2'd0, 18'h0, 1'b1};
    vecs[9]  = '{4'b0001, 4'b0001, 2'd0, D0,    1'b1};
    vecs[10] = '{4'b0000, 4'b0000, 2'd0, 18'h0, 1'b0};
    vecs[11] = '{4'b0001, 4'b0001, 2'd0, D0,    1'b1};
    vecs[12] = '{4'b1000, 4'b0000, 2'd0, 18'h0, 1'b0};
    vecs[13] = '{4'b1000, 4'b0000, 2'd3, 18'h0, 1'b1};
    vecs[14] = '{4'b0000, 4'b0000, 2'd3, 18'h0, 1'b0};
    vecs[15] = '{4'b0000, 4'b0000, 2'd3, 18'h0, 1'b0};
    vecs[16] = '{4'b0101, 4'b0000, 2'd2, 18'h0, 1'b1};
    vecs[17] = '{4'b0101, 4'b0000, 2'd2, 18'h0, 1'b1};
    vecs[18] = '{4'b0101, 4'b0100, 2'd2, D2,    1'b1};

    // Table: guard entry, grant, release, same-select regrant, aborted guard.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      req_i = vecs[i].req;
      step();
      chk($sformatf("v%0d.gnt", i),  32'(gnt_o),     32'(vecs[i].gnt));
      chk($sformatf("v%0d.sel", i),  32'(sel_o),     32'(vecs[i].sel));
      chk($sformatf("v%0d.pad", i),  32'(pad_out_o), 32'(vecs[i].pad));
      chk($sformatf("v%0d.busy", i), 32'(busy_o),    32'(vecs[i].busy));
      chk($sformatf("v%0d.vld", i),  32'(in_vld_o),  32'(vecs[i].gnt));
      $display("vec %0d req=%b gnt=%b sel=%0d pad=%h busy=%b", i, req_i, gnt_o, sel_o, pad_out_o, busy_o);
    end
    chk("in_o", 32'(in_o), 32'h2BCDE1);

    // All four requesting: round-robin with 65-cycle tenure and 3-cycle gaps.
    do_reset();
    req_i = 4'b1111;
    run_idx = 0; cur_len = 0; gap = 0; viol = 0;
    prev_gnt = '0; prev_sel = '0;
    for (int i = 0; i < 8; i++) begin owners[i] = -1; lens[i] = 0; end
    for (int c = 0; c < 400; c++) begin
      step();
      g = gnt_o;
      if (g != 0 && ((g & (g - 4'd1)) != 0)) viol++;
      if (g != 0 && !g[sel_o]) viol++;
      if (prev_gnt != 0 && g != 0 && sel_o != prev_sel) viol++;
      if (g != 0) begin
        if (prev_gnt == 0) begin
          if (run_idx < 8) owners[run_idx] = idx_of(g);
          if (run_idx > 0) chk($sformatf("rr.gap%0d", run_idx), 32'(gap), 32'd3);
          cur_len = 0;
        end
        cur_len++;
      end else begin
        if (prev_gnt != 0) begin
          if (run_idx < 8) lens[run_idx] = cur_len;
          $display("rr run %0d owner=%0d len=%0d", run_idx, owners[run_idx], cur_len);
          run_idx++;
          gap = 0;
        end
        gap++;
      end
      prev_gnt = g;
      prev_sel = sel_o;
    end
    chk("rr.viol", 32'(viol), 32'd0);
    chk("rr.owner0", 32'(owners[0]), 32'd0);
    chk("rr.owner1", 32'(owners[1]), 32'd1);
    chk("rr.owner2", 32'(owners[2]), 32'd2);
    chk("rr.owner3", 32'(owners[3]), 32'd3);
    chk("rr.owner4", 32'(owners[4]), 32'd0);
    for (int i = 0; i < 5; i++) chk($sformatf("rr.len%0d", i), 32'(lens[i]), 32'd65);

    // Lone owner saturates without preemption, then yields to a late requester.
    do_reset();
    req_i = 4'b0100;
    step(); step(); step();
    chk("hold.gnt3", 32'(gnt_o), 32'b0100);
    bad = 0;
    for (int c = 3; c < 150; c++) begin
      step();
      if (gnt_o != 4'b0100) bad++;
    end
    chk("hold.nopreempt", 32'(bad), 32'd0);
    $display("hold owner2 held through cycle 150 bad=%0d", bad);
    req_i = 4'b0101;
    step();
    chk("pre.gnt_drop", 32'(gnt_o), 32'h0);
    chk("pre.busy_idle", 32'(busy_o), 32'h0);
    step();
    chk("pre.sel_guard", 32'(sel_o), 32'd0);
    chk("pre.busy_guard", 32'(busy_o), 32'h1);
    chk("pre.gnt_guard", 32'(gnt_o), 32'h0);
    step();
    chk("pre.gnt_guard2", 32'(gnt_o), 32'h0);
    step();
    chk("pre.gnt_new", 32'(gnt_o), 32'b0001);
    chk("pre.pad_new", 32'(pad_out_o), 32'(D0));
    $display("preempt owner2 -> owner0 gnt=%b pad=%h", gnt_o, pad_out_o);

    // Asynchronous reset in the middle of an ownership.
    d[1] = 18'h3FFFF;
    do_reset();
    req_i = 4'b0010;
    step(); step(); step();
    chk("ar.gnt_own", 32'(gnt_o), 32'b0010);
    chk("ar.pad_own", 32'(pad_out_o), 32'h3FFFF);
    #1;
    rst_i = 1'b1;
    #1;
    chk("ar.gnt", 32'(gnt_o), 32'h0);
    chk("ar.sel", 32'(sel_o), 32'h0);
    chk("ar.pad", 32'(pad_out_o), 32'h0);
    chk("ar.busy", 32'(busy_o), 32'h0);
    rst_i = 1'b0;
    req_i = 4'b1010;
    step();
    chk("ar.sel_after", 32'(sel_o), 32'd1);
    chk("ar.gnt_guard", 32'(gnt_o), 32'h0);
    step(); step();
    chk("ar.gnt_after", 32'(gnt_o), 32'b0010);
    $display("async reset recovery gnt=%b sel=%0d", gnt_o, sel_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
